// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: sequential instruction prefetcher with a req/ack memory side and a valid/ready FIFO to decode
// Ports: clk/reset (async, active-high); mem_req/mem_addr/mem_ack/mem_rdata fetch handshake;
// redirect/redirect_pc branch restart; out_valid/out_ready/instr/instr_pc_plus4 decode handshake; count = valid entries.
// Option: PREFETCH_BYPASS_EN presents an acked word straight to decode when the queue is empty.
module instr_prefetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              instr,
    output logic [31:0]              instr_pc_plus4,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
    state_t        state;
    logic [31:0]   fpc, drop_addr, tgt;
    logic [31:0]   q_word [DEPTH];
    logic [31:0]   q_pc4 [DEPTH];
    logic [PW-1:0] rptr, wptr;
    logic [CW-1:0] count_next;
    logic          ack, fifo_valid, bypass, push, pop;
    assign tgt        = redirect_pc & ~32'd3;
    assign ack        = (state == REQ) && mem_ack;
    assign fifo_valid = count != '0;
`ifdef PREFETCH_BYPASS_EN
    assign bypass = !fifo_valid && ack && !redirect;
`else
    assign bypass = 1'b0;
`endif
    assign pop        = fifo_valid && out_ready && !redirect;
    // a bypassed word taken by decode in the same cycle never enters the FIFO
    assign push       = ack && !redirect && !(bypass && out_ready);
    assign count_next = count + CW'(push) - CW'(pop);
    assign mem_req        = state != IDLE;
    assign mem_addr       = (state == DROP) ? drop_addr : fpc;
    assign out_valid      = fifo_valid || bypass;
    assign instr          = bypass ? mem_rdata : fifo_valid ? q_word[rptr] : '0;
    assign instr_pc_plus4 = bypass ? fpc + 32'd4 : fifo_valid ? q_pc4[rptr] : '0;
    always_ff @(posedge clk) begin
        if (push) begin
            q_word[wptr] <= mem_rdata;
            q_pc4[wptr]  <= fpc + 32'd4;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            fpc       <= '0;
            drop_addr <= '0;
            rptr      <= '0;
            wptr      <= '0;
            count     <= '0;
        end else begin
            if (redirect) begin
                rptr  <= '0;
                wptr  <= '0;
                count <= '0;
            end else begin
                rptr  <= rptr + PW'(pop);
                wptr  <= wptr + PW'(push);
                count <= count_next;
            end
            fpc <= redirect ? tgt : ack ? fpc + 32'd4 : fpc;
            case (state)
                IDLE: if (!redirect && count < CW'(DEPTH)) state <= REQ;
                REQ: begin
                    if (mem_ack)
                        state <= (!redirect && count_next < CW'(DEPTH)) ? REQ : IDLE;
                    else if (redirect) begin
                        // the outstanding request cannot be retracted; keep its address until the ack
                        state     <= DROP;
                        drop_addr <= fpc;
                    end
                end
                DROP: if (mem_ack) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: randomized/directed bench for instr_prefetch_queue against a queue-based model
module tb_instr_prefetch_queue;
    localparam int DEPTH = 4;
`ifdef PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        clk = 0, reset = 1;
    logic        mem_req, mem_ack = 0, redirect = 0, out_valid, out_ready = 0;
    logic [31:0] mem_addr, mem_rdata = 0, redirect_pc = 0, instr, instr_pc_plus4;
    logic [$clog2(DEPTH):0] count;
    int checks = 0, errors = 0;
    // model: fetch mode 0 idle, 1 requesting, 2 waiting to discard
    int          m_mode, w, lat_lo, lat_hi;
    logic [31:0] m_fpc, m_daddr;
    logic [63:0] q[$];

    instr_prefetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_ready(out_ready), .instr(instr), .instr_pc_plus4(instr_pc_plus4), .count(count)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, " mem_addr"}, mem_addr, 32'd0);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " instr"}, instr, 32'd0);
        chk({tag, " pc4"}, instr_pc_plus4, 32'd0);
        chk({tag, " count"}, 32'(count), 32'd0);
    endtask

    task automatic do_reset(input bit async_mid);
        if (async_mid) #2 reset = 1;
        else begin
            @(negedge clk);
            reset = 1;
        end
        redirect = 0;
        mem_ack = 0;
        out_ready = 0;
        #1 chk_zero(async_mid ? "async_rst" : "rst");
        @(negedge clk);
        reset = 0;
        q.delete();
        m_fpc = 0;
        m_daddr = 0;
        m_mode = 0;
        w = $urandom_range(lat_hi, lat_lo);
        #1 chk_zero("rst_rel");
        @(posedge clk);
        m_mode = 1;
    endtask

    task automatic step(input bit rd, input logic [31:0] rpc, input bit rdy);
        logic [31:0] t, addr, word;
        bit ack, byp;
        int osz;
        @(negedge clk);
        t = rpc & ~32'd3;
        addr = (m_mode == 2) ? m_daddr : m_fpc;
        word = addr ^ 32'hA5A50000;
        ack = 0;
        if (m_mode != 0) begin
            if (w == 0) begin
                ack = 1;
                w = $urandom_range(lat_hi, lat_lo);
            end else w--;
        end
        redirect = rd;
        redirect_pc = rpc;
        out_ready = rdy;
        mem_ack = ack;
        mem_rdata = ack ? word : $urandom;
        byp = BYP && q.size() == 0 && m_mode == 1 && ack && !rd;
        #1;
        chk("mem_req", 32'(mem_req), 32'(m_mode != 0));
        if (m_mode != 0) chk("mem_addr", mem_addr, addr);
        chk("count", 32'(count), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0 || byp));
        if (byp) begin
            chk("instr_byp", instr, word);
            chk("pc4_byp", instr_pc_plus4, m_fpc + 32'd4);
        end else if (q.size() != 0) begin
            chk("instr", instr, q[0][63:32]);
            chk("pc4", instr_pc_plus4, q[0][31:0]);
        end
        @(posedge clk);
        osz = q.size();
        if (rd) q.delete();
        else begin
            if (osz != 0 && rdy) void'(q.pop_front());
            if (m_mode == 1 && ack && !(byp && rdy)) q.push_back({word, m_fpc + 32'd4});
        end
        if (m_mode == 0) begin
            if (rd) m_fpc = t;
            else if (osz < DEPTH) m_mode = 1;
        end else if (m_mode == 1) begin
            if (!ack) begin
                if (rd) begin
                    m_daddr = m_fpc;
                    m_fpc = t;
                    m_mode = 2;
                end
            end else if (rd) begin
                m_fpc = t;
                m_mode = 0;
            end else begin
                m_fpc = m_fpc + 32'd4;
                m_mode = (q.size() < DEPTH) ? 1 : 0;
            end
        end else begin
            if (rd) m_fpc = t;
            if (ack) m_mode = 0;
        end
    endtask

    initial begin
        lat_lo = 0;
        lat_hi = 0;
        do_reset(0);
        repeat (20) step(0, 0, 1);
        do_reset(0);
        repeat (8) step(0, 0, 0);
        chk("sat_count", 32'(count), 32'(DEPTH));
        chk("sat_req", 32'(mem_req), 32'd0);
        repeat (10) step(0, 0, 1);
        lat_lo = 3;
        lat_hi = 3;
        do_reset(0);
        step(0, 0, 1);
        step(1, 32'h103, 1);
        repeat (10) step(0, 0, 1);
        lat_lo = 0;
        lat_hi = 0;
        do_reset(0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 32'h40, 1);
        repeat (4) step(0, 0, 1);
        step(1, 32'hFFFFFFFC, 1);
        repeat (6) step(0, 0, 1);
        lat_hi = 3;
        repeat (400) step($urandom_range(15, 0) == 0, $urandom, $urandom_range(3, 0) != 0);
        lat_lo = 3;
        do_reset(0);
        step(0, 0, 1);
        lat_lo = 0;
        lat_hi = 0;
        do_reset(1);
        repeat (10) step(0, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Fetch front-end that sits directly upstream of the pipelined MIPS IF/ID register. It issues sequential word fetches to a variable-latency instruction memory over a req/ack handshake. Returned words are buffered in a small FIFO and handed to the decode stage with a valid/ready handshake. Branch redirects from EX flush the queue and restart fetching at the target, and any in-flight memory response is safely discarded.

## Interface
- `DEPTH`, default 4: FIFO entries; a power of two, at least 2.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `mem_req`  output  1  fetch request; held high until acked.
- `mem_addr`  output  32  word-aligned fetch address; stable while `mem_req` is high.
- `mem_ack`  input  1  one-cycle response strobe; only meaningful while `mem_req` is high.
- `mem_rdata`  input  32  instruction word; valid in the cycle `mem_ack` is high.
- `redirect`  input  1  flush queue and restart at `redirect_pc` (the core's PCSrc).
- `redirect_pc`  input  32  new fetch PC; bits [1:0] are forced to 0.
- `out_valid`  output  1  the head entry is valid.
- `out_ready`  input  1  the decode stage accepts the head (low during a load-use stall).
- `instr`  output  32  head instruction word.
- `instr_pc_plus4`  output  32  PC of the head instruction + 4, feeding the IF/ID PC+4 field.
- `count`  output  $clog2(DEPTH)+1  number of valid entries.

## Operation
- Registers:
  - fetch PC `fpc`, resets to 0.
  - FIFO of {word, pc+4} with read and write pointers (mod DEPTH) and `count`.
  - FSM with states IDLE, REQ, DROP.
- `mem_req` = (state != IDLE). `mem_addr` = `fpc` in REQ; in DROP it is the address latched when DROP was entered.
- IDLE:
  - No redirect and count < DEPTH → REQ.
  - Redirect → `fpc` = target; stay IDLE for this cycle.
- REQ without ack:
  - Hold the request.
  - Redirect → DROP, `fpc` = target. The request cannot be retracted.
- REQ with ack, no redirect:
  - Push {`mem_rdata`, `fpc`+4`}, then `fpc` += 4 (wraps 0xFFFFFFFC → 0).
  - If the post-edge count (count + 1 − pop) < DEPTH, stay in REQ with the new address (back-to-back fetches). Otherwise go to IDLE.
- REQ with ack and redirect in the same cycle: the word is discarded, `fpc` = target, state → IDLE.
- DROP:
  - Ack → discard the word, go to IDLE.
  - Redirect → update `fpc` again, stay in DROP.
- Pop: `out_valid` && `out_ready` && !`redirect` advances the read pointer.
- Redirect empties the FIFO (pointers and count reset to 0) and wins over a simultaneous pop or push.
- Push and pop in the same cycle leave count unchanged. A push never happens when count == DEPTH; the issue rule guarantees this.
- `out_valid` = (count != 0). `instr` and `instr_pc_plus4` show the head entry and hold it while `out_ready` is low.

## Timing
- Reset values:
  - `mem_req` 0, `mem_addr` 0, `out_valid` 0, `instr` 0, `instr_pc_plus4` 0, `count` 0.
  - State IDLE, `fpc` 0.
- Behaviour after reset release:
  - First edge → REQ, so `mem_req` is high in cycle 1 with `mem_addr` = 0.
  - Reset asserted mid-transaction aborts the transaction immediately, with no pending DROP.
- Latency:
  - Ack at edge N → `out_valid` high in cycle N+1 (base build).
  - Redirect at edge N → `mem_req` for the target in cycle N+2, since IDLE lasts one cycle. In DROP it comes one cycle after the discarded ack.
- Throughput: 1 instruction/cycle with a zero-wait memory (ack in the same cycle as req) and `out_ready` tied high.

## Configuration
- `PREFETCH_BYPASS_EN`
  - Defined: when count == 0, the state is REQ and `mem_ack` is high with no redirect, the word is presented combinationally in the same cycle. `out_valid` = 1, `instr` = `mem_rdata`, `instr_pc_plus4` = `fpc`+4. If `out_ready` is also high, the word is consumed without being written to the FIFO. This is a zero-cycle fetch-to-decode path.
  - Undefined: every word passes through the FIFO, giving 1 cycle of latency, and all outputs are register-driven.

## Test plan
- Zero-wait memory returning `mem_rdata` = addr ^ 0xA5A50000, `out_ready` = 1 → addresses 0, 4, 8, … one per cycle; `instr_pc_plus4` = 4, 8, 12, …; no gaps after the first word.
- Hold `out_ready` = 0 → count saturates at 4, `mem_req` drops, `fpc` = 0x10. Then release → 4 pops in order with fetching resumed.
- Memory with 3-cycle ack latency; redirect to 0x103 while REQ is pending → `mem_addr` held at the old address until the ack, word discarded, next request at 0x100, `out_valid` stays 0 meanwhile.
- Redirect to 0x40 in the same cycle as ack and a pop with count = 2 → count = 0, no push, next `mem_addr` = 0x40.
- Redirect to 0xFFFFFFFC, zero-wait memory → fetches 0xFFFFFFFC then 0x0; `instr_pc_plus4` = 0x0 then 0x4.
- Assert `reset` asynchronously mid-REQ → all outputs 0 before the next edge; fetching restarts from 0. With `PREFETCH_BYPASS_EN`: first word visible in the ack cycle with count remaining 0.
